// File: rtl/wb_master_arb_if.sv
// Bus bundle for wb_master_arb: data-side and instruction-side
// Wishbone masters plus the shared master port they are muxed onto.
interface wb_master_arb_if;
    logic        d_cyc_i;
    logic        d_stb_i;
    logic        d_we_i;
    logic [29:0] d_addr_i;
    logic [2:0]  d_cti_i;
    logic [1:0]  d_bte_i;
    logic [3:0]  d_sel_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ack_o;
    logic        d_err_o;

    logic        i_cyc_i;
    logic        i_stb_i;
    logic        i_we_i;
    logic [29:0] i_addr_i;
    logic [2:0]  i_cti_i;
    logic [1:0]  i_bte_i;
    logic [3:0]  i_sel_i;
    logic [31:0] i_data_i;
    logic [31:0] i_data_o;
    logic        i_ack_o;
    logic        i_err_o;

    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [29:0] wbm_addr_o;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_data_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;

    modport master (
        input  d_cyc_i, d_stb_i, d_we_i, d_addr_i,
        input  d_cti_i, d_bte_i, d_sel_i, d_data_i,
        output d_data_o, d_ack_o, d_err_o,
        input  i_cyc_i, i_stb_i, i_we_i, i_addr_i,
        input  i_cti_i, i_bte_i, i_sel_i, i_data_i,
        output i_data_o, i_ack_o, i_err_o,
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o,
        output wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_data_o,
        input  wbm_data_i, wbm_ack_i
    );

    modport slave (
        output d_cyc_i, d_stb_i, d_we_i, d_addr_i,
        output d_cti_i, d_bte_i, d_sel_i, d_data_i,
        input  d_data_o, d_ack_o, d_err_o,
        output i_cyc_i, i_stb_i, i_we_i, i_addr_i,
        output i_cti_i, i_bte_i, i_sel_i, i_data_i,
        input  i_data_o, i_ack_o, i_err_o,
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_addr_o,
        input  wbm_cti_o, wbm_bte_o, wbm_sel_o, wbm_data_o,
        output wbm_data_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_master_arb.sv
// Two-master Wishbone arbiter (DCMU/ICMU) onto one shared bus:
// round-robin on contention, no preemption, stuck-slave timeout.
module wb_master_arb #(
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_BITS = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    wb_master_arb_if.master bus,
    output logic            grant_d,
    output logic            grant_i,
    output logic            timeout_flag
);
    typedef enum logic [1:0] {IDLE, OWN_D, OWN_I, ERR} state_t;

    localparam logic [CNT_BITS:0] TMO = (CNT_BITS+1)'(TIMEOUT);

    state_t              state_q, state_d;
    logic                last_i_q, last_i_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic                flag_q, flag_d;
    logic                own_cyc, own_stb, hit;
    logic [CNT_BITS:0]   cnt_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_i_q <= 1'b1;
            cnt_q    <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_i_q <= last_i_d;
            cnt_q    <= cnt_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        unique case (state_q)
            OWN_D: begin
                own_cyc = bus.d_cyc_i;
                own_stb = bus.d_stb_i;
            end
            OWN_I: begin
                own_cyc = bus.i_cyc_i;
                own_stb = bus.i_stb_i;
            end
            default: ;
        endcase
    end

    // hit marks the wait cycle in which the counter would reach TIMEOUT
    assign cnt_inc = {1'b0, cnt_q} + (CNT_BITS+1)'(1);
    assign hit = (TIMEOUT != 0) && own_cyc && own_stb
               && !bus.wbm_ack_i && (cnt_inc == TMO);

    always_comb begin
        state_d  = state_q;
        last_i_d = last_i_q;
        flag_d   = flag_q;
        unique case (state_q)
            IDLE: begin
                if (bus.d_cyc_i && (!bus.i_cyc_i || last_i_q)) begin
                    state_d  = OWN_D;
                    last_i_d = 1'b0;
                end else if (bus.i_cyc_i) begin
                    state_d  = OWN_I;
                    last_i_d = 1'b1;
                end
            end
            OWN_D: begin
                if (!bus.d_cyc_i) begin
                    state_d  = bus.i_cyc_i ? OWN_I : IDLE;
                    last_i_d = bus.i_cyc_i;
                end else if (hit) begin
                    state_d = ERR;
                    flag_d  = 1'b1;
                end
            end
            OWN_I: begin
                if (!bus.i_cyc_i) begin
                    state_d  = bus.d_cyc_i ? OWN_D : IDLE;
                    last_i_d = !bus.d_cyc_i;
                end else if (hit) begin
                    state_d = ERR;
                    flag_d  = 1'b1;
                end
            end
            ERR: begin
                // last_i_q still names the master that timed out
                if (last_i_q ? !bus.i_cyc_i : !bus.d_cyc_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_d == state_q && own_stb && !bus.wbm_ack_i
            && (state_q == OWN_D || state_q == OWN_I))
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
    end

    always_comb begin
        grant_d = (state_q == OWN_D);
        grant_i = (state_q == OWN_I);

        bus.wbm_cyc_o  = own_cyc;
        bus.wbm_stb_o  = own_stb;
        bus.wbm_we_o   = 1'b0;
        bus.wbm_addr_o = '0;
        bus.wbm_cti_o  = '0;
        bus.wbm_bte_o  = '0;
        bus.wbm_sel_o  = '0;
        bus.wbm_data_o = '0;
        unique case (1'b1)
            grant_d: begin
                bus.wbm_we_o   = bus.d_we_i;
                bus.wbm_addr_o = bus.d_addr_i;
                bus.wbm_cti_o  = bus.d_cti_i;
                bus.wbm_bte_o  = bus.d_bte_i;
                bus.wbm_sel_o  = bus.d_sel_i;
                bus.wbm_data_o = bus.d_data_i;
            end
            grant_i: begin
                bus.wbm_we_o   = bus.i_we_i;
                bus.wbm_addr_o = bus.i_addr_i;
                bus.wbm_cti_o  = bus.i_cti_i;
                bus.wbm_bte_o  = bus.i_bte_i;
                bus.wbm_sel_o  = bus.i_sel_i;
                bus.wbm_data_o = bus.i_data_i;
            end
            default: ;
        endcase

        bus.d_ack_o  = bus.wbm_ack_i & grant_d;
        bus.i_ack_o  = bus.wbm_ack_i & grant_i;
        bus.d_err_o  = hit & grant_d;
        bus.i_err_o  = hit & grant_i;
        bus.d_data_o = grant_d ? bus.wbm_data_i : '0;
        bus.i_data_o = grant_i ? bus.wbm_data_i : '0;
    end

    assign timeout_flag = flag_q;
endmodule

// File: doc/wb_master_arb.md
WB_MASTER_ARB -- requirements
Module: wb_master_arb

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles owner stb may wait for ack; 0 disables timeout.
REQ-002 Parameter CNT_BITS, default 8: timeout counter width; SHALL hold TIMEOUT.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 d_cyc_i, d_stb_i, d_we_i  in  1 each  data-side (DCMU) master controls.
REQ-006 d_addr_i in 30 [31:2], d_cti_i in 3, d_bte_i in 2, d_sel_i in 4, d_data_i in 32  data-side request fields.
REQ-007 d_data_o out 32, d_ack_o out 1, d_err_o out 1  data-side responses.
REQ-008 i_cyc_i..i_data_i, i_data_o, i_ack_o, i_err_o  same widths as REQ-005..007  instruction-side (ICMU) master.
REQ-009 wbm_cyc_o, wbm_stb_o, wbm_we_o out 1; wbm_addr_o out 30; wbm_cti_o out 3; wbm_bte_o out 2; wbm_sel_o out 4; wbm_data_o out 32  shared bus master.
REQ-010 wbm_data_i in 32, wbm_ack_i in 1  shared bus responses.
REQ-011 grant_d, grant_i  out  1 each  current owner; never both 1.
REQ-012 timeout_flag  out  1  sticky; set on any timeout, cleared only by reset.

Function
REQ-013 States IDLE, OWN_D, OWN_I, ERR; encoded in registers; grant_d=1 only in OWN_D, grant_i=1 only in OWN_I.
REQ-014 IDLE: d_cyc_i only -> OWN_D next cycle; i_cyc_i only -> OWN_I; both -> side not granted last (last_owner register); neither -> stay.
REQ-015 last_owner resets to I, so first contended grant goes to D.
REQ-016 Arbitration latency: grant asserted exactly 1 cycle after cyc seen in IDLE.
REQ-017 In OWN_x: all wbm_* request outputs are x's inputs; wbm_cyc_o/wbm_stb_o = x_cyc_i/x_stb_i; outside OWN_D/OWN_I wbm_cyc_o=wbm_stb_o=0, other outputs don't-care but SHALL be 0.
REQ-018 x_ack_o = wbm_ack_i & grant_x; x_data_o = wbm_data_i when granted, else 0; non-owner ack/err SHALL be 0.
REQ-019 No preemption: owner keeps grant while x_cyc_i=1, including full bursts (cti 010 through 111) and lock sequences.
REQ-020 Owner drops cyc: other side requesting -> direct handoff to other OWN state next cycle (last_owner updated); else IDLE.
REQ-021 Timeout counter clears on grant change, on wbm_ack_i, and when owner stb=0; increments each cycle owner stb=1 and ack=0; saturates.
REQ-022 Counter reaching TIMEOUT (TIMEOUT>0): x_err_o=1 for exactly that cycle, timeout_flag set, state -> ERR next cycle.
REQ-023 ERR: wbm_cyc_o=0, no grant; stay until former owner's cyc_i=0, then IDLE (last_owner = former owner).
REQ-024 ack and timeout in same cycle: ack wins, no err.
REQ-025 Simultaneous owner cyc drop and other request arrival: handoff per REQ-020, no idle cycle.

Reset
REQ-026 rst_n low: state IDLE, counter 0, last_owner I, timeout_flag 0, all outputs 0, immediately (asynchronous), including mid-transfer.
REQ-027 Exit from reset synchronous to clk; first grant no earlier than 1 cycle after rst_n high.

Verification
REQ-028 D single read, slave acks after 3 cycles -> grant_d next cycle, d_ack_o 1 cycle with wbm_data_i, i_ack_o stays 0, back to IDLE after d_cyc_i drop.
REQ-029 D and I assert cyc same cycle after reset -> D granted first; I granted cycle after d_cyc_i drops; next contention goes to D again (round-robin alternates).
REQ-030 I 4-beat burst (cti 010,010,010,111) while D requests at beat 2 -> no preemption; D granted directly following I cyc drop.
REQ-031 TIMEOUT=4, slave never acks D -> d_err_o pulses once at 4th wait cycle, timeout_flag=1, wbm_cyc_o=0 until d_cyc_i low, then IDLE.
REQ-032 rst_n low mid-burst -> all outputs 0 same cycle without clock edge; after release, pending I request granted 1 cycle later.
